data_mem_copier: RTL and testbench
==================================

// Module: data_mem_copier
// PURPOSE
//   Initiator side of the data memory port: a block-copy engine that issues ReadMem/WriteMem
//   strobes to copy Length bytes from SrcAddr to DstAddr inside the data memory.
//   Sits between the control path (Start/Busy/Done) and the data memory, which has a
//   registered read with 1-cycle latency (DataOut valid the cycle after ReadMem is sampled).
//   Used for memcpy-style bulk moves without occupying the datapath.
// PARAMETERS
//   ADDR_WIDTH  8  data memory address width; address space 2**ADDR_WIDTH bytes
//   DATA_WIDTH  8  data memory word width
// PORTS
//   CLK          in   1           clock, all state on posedge
//   Reset        in   1           synchronous, active-high reset
//   Start        in   1           request copy; sampled only in IDLE
//   SrcAddr      in   ADDR_WIDTH  first source address, captured on accepted Start
//   DstAddr      in   ADDR_WIDTH  first destination address, captured on accepted Start
//   Length       in   ADDR_WIDTH  byte count, captured on accepted Start; 0 = no-op
//   Busy         out  1           high in RD and WR states
//   Done         out  1           1-cycle pulse in DONE state
//   Remaining    out  ADDR_WIDTH  bytes not yet written
//   DataAddress  out  ADDR_WIDTH  memory address
//   ReadMem      out  1           memory read strobe
//   WriteMem     out  1           memory write strobe
//   DataIn       out  DATA_WIDTH  memory write data
//   MemRdData    in   DATA_WIDTH  memory DataOut (registered, 1-cycle latency)
// BEHAVIOUR
//   - FSM states: IDLE, RD, WR, DONE. All outputs are Moore-decoded from registered state and
//     registered pointers, except DataIn = MemRdData in WR (0 otherwise).
//   - Reset: state=IDLE, src/dst pointers=0, Remaining=0; Busy=Done=ReadMem=WriteMem=0,
//     DataAddress=0, DataIn=0. Reset mid-copy aborts immediately; no Done pulse is issued,
//     bytes already written stay written.
//   - IDLE: Start=1 & Length!=0 -> capture src/dst/Length, go RD. Start=1 & Length==0 -> DONE
//     (no memory access). Start outside IDLE is ignored (not queued).
//   - RD: ReadMem=1, DataAddress=src. -> WR.
//   - WR: WriteMem=1, DataAddress=dst, DataIn=MemRdData (value read in previous RD);
//     src++, dst++ (mod 2**ADDR_WIDTH, wrap 0xFF->0x00), Remaining--.
//     Remaining reaches 0 -> DONE, else -> RD.
//   - DONE: Done=1 for exactly one cycle, Busy=0 -> IDLE. Start in DONE is ignored.
//   - Latency: Start sampled at edge k; N bytes occupy 2N cycles (k+1..k+2N);
//     Done high in cycle k+2N+1; next Start accepted at the edge ending that cycle + 1 (IDLE).
//   - ReadMem and WriteMem are never high in the same cycle.
//   - Overlap: strictly ascending byte-at-a-time read-then-write. With DstAddr=SrcAddr+1 the
//     first byte propagates (fill semantics); this is the defined behaviour, not an error.
//   - Length field max 2**ADDR_WIDTH-1 bytes; pointer wrap past top of memory is silent.
// TESTING
//   1. Mem[0x10..0x13]=A1,B2,C3,D4; Start src=0x10 dst=0x80 len=4 -> Mem[0x80..0x83]=A1,B2,C3,D4,
//      Busy 8 cycles, Done 1 cycle at k+9, 4 ReadMem + 4 WriteMem strobes alternating.
//   2. Start len=0 -> Done at k+1, ReadMem/WriteMem never asserted, Busy stays 0.
//   3. src=0xFE dst=0x40 len=3 -> reads 0xFE,0xFF,0x00 (wrap); Mem[0x40..0x42] match.
//   4. Mem[0x20]=5A; src=0x20 dst=0x21 len=3 -> Mem[0x21..0x23]=5A,5A,5A (overlap propagation).
//   5. len=8, assert Reset in 2nd WR cycle -> next cycle all outputs 0, IDLE, no Done; only
//      first byte copied (plus the write in the Reset cycle itself if Reset sampled after it).
//   6. Start pulsed during Busy with different args -> ignored; Remaining counts 4,3,2,1,0 unaffected.

Source files
------------

// File: rtl/data_mem_copier_if.sv
// rtl/data_mem_copier_if.sv - control and data memory signals of the block-copy engine
interface data_mem_copier_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  Start;
  logic [ADDR_WIDTH-1:0] SrcAddr;
  logic [ADDR_WIDTH-1:0] DstAddr;
  logic [ADDR_WIDTH-1:0] Length;
  logic                  Busy;
  logic                  Done;
  logic [ADDR_WIDTH-1:0] Remaining;
  logic [ADDR_WIDTH-1:0] DataAddress;
  logic                  ReadMem;
  logic                  WriteMem;
  logic [DATA_WIDTH-1:0] DataIn;
  logic [DATA_WIDTH-1:0] MemRdData;

  // Copier side: takes commands and memory read data, drives status and memory strobes
  modport master (
    input  Start, SrcAddr, DstAddr, Length, MemRdData,
    output Busy, Done, Remaining, DataAddress, ReadMem, WriteMem, DataIn
  );

  // Environment side: control path plus the data memory
  modport slave (
    output Start, SrcAddr, DstAddr, Length, MemRdData,
    input  Busy, Done, Remaining, DataAddress, ReadMem, WriteMem, DataIn
  );
endinterface

// File: rtl/data_mem_copier.sv
// rtl/data_mem_copier.sv - byte-at-a-time memcpy engine driving the data memory port
module data_mem_copier #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic               CLK,
  input  logic               Reset,
  data_mem_copier_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;

  // State and pointer registers; reset aborts any copy in flight without a Done pulse
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic: one read then one write per byte; pointers wrap silently
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          if (bus.Length != '0) begin
            src_d   = bus.SrcAddr;
            dst_d   = bus.DstAddr;
            rem_d   = bus.Length;
            state_d = ST_RD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RD: begin
        state_d = ST_WR;
      end
      ST_WR: begin
        src_d   = src_q + 1'b1;
        dst_d   = dst_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == {{(ADDR_WIDTH-1){1'b0}}, 1'b1}) ? ST_DONE : ST_RD;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs; only DataIn passes memory read data through, and only while writing
  always_comb begin
    bus.Busy        = 1'b0;
    bus.Done        = 1'b0;
    bus.ReadMem     = 1'b0;
    bus.WriteMem    = 1'b0;
    bus.DataAddress = '0;
    bus.DataIn      = '0;
    bus.Remaining   = rem_q;
    unique case (state_q)
      ST_RD: begin
        bus.Busy        = 1'b1;
        bus.ReadMem     = 1'b1;
        bus.DataAddress = src_q;
      end
      ST_WR: begin
        bus.Busy        = 1'b1;
        bus.WriteMem    = 1'b1;
        bus.DataAddress = dst_q;
        bus.DataIn      = bus.MemRdData;
      end
      ST_DONE: begin
        bus.Done        = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem_copier.sv
// tb/tb_data_mem_copier.sv - directed self-checking bench for data_mem_copier
module tb_data_mem_copier;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [7:0] mem [256];
  logic [7:0] rd_q;
  logic       tb_we;
  logic [7:0] tb_addr;
  logic [7:0] tb_data;

  data_mem_copier_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  data_mem_copier #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: registered read, one cycle latency; bench preload port has priority
  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (bus.WriteMem) mem[bus.DataAddress] <= bus.DataIn;
    if (bus.ReadMem) rd_q <= mem[bus.DataAddress];
  end
  assign bus.MemRdData = rd_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    step();
    tb_we = 1'b0;
  endtask

  // Leaves the bench 1 time unit into cycle k+1, where edge k sampled Start
  task automatic start_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    bus.Start = 1'b1; bus.SrcAddr = s; bus.DstAddr = d; bus.Length = l;
    step();
    bus.Start = 1'b0;
  endtask

  task automatic check_mem(input string name, input logic [7:0] a, input logic [7:0] exp);
    checks++;
    if (mem[a] !== exp) begin
      failures++;
      $display("FAIL %s mem[%02h] actual=%02h required=%02h", name, a, mem[a], exp);
    end
  endtask

  // Compares {Busy,Done,ReadMem,WriteMem,DataAddress} of the current cycle
  task automatic check_outs(input string name, input int cyc, input logic [11:0] exp);
    logic [11:0] act;
    act = {bus.Busy, bus.Done, bus.ReadMem, bus.WriteMem, bus.DataAddress};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d busy/done/rd/wr/addr actual=%03h required=%03h", name, cyc, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check_outs("reset_outs", 0, 12'h000);
    checks++;
    if ({bus.Remaining, bus.DataIn} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_rem_datain actual=%04h required=0000", {bus.Remaining, bus.DataIn});
    end
  endtask

  task automatic test_basic_copy();
    logic [7:0] src_bytes [4];
    src_bytes[0] = 8'hA1; src_bytes[1] = 8'hB2; src_bytes[2] = 8'hC3; src_bytes[3] = 8'hD4;
    for (int i = 0; i < 4; i++) poke(8'h10 + 8'(i), src_bytes[i]);
    start_copy(8'h10, 8'h80, 8'd4);
    for (int c = 1; c <= 8; c++) begin
      if (c % 2 == 1) begin
        check_outs("basic_rd", c, {4'b1010, 8'h10 + 8'((c - 1) / 2)});
      end else begin
        check_outs("basic_wr", c, {4'b1001, 8'h80 + 8'((c - 2) / 2)});
        checks++;
        if (bus.DataIn !== src_bytes[(c - 2) / 2]) begin
          failures++;
          $display("FAIL basic_datain cycle=%0d actual=%02h required=%02h", c, bus.DataIn, src_bytes[(c - 2) / 2]);
        end
      end
      step();
    end
    check_outs("basic_done", 9, 12'h400);
    step();
    check_outs("basic_idle", 10, 12'h000);
    for (int i = 0; i < 4; i++) check_mem("basic_mem", 8'h80 + 8'(i), src_bytes[i]);
  endtask

  task automatic test_zero_length();
    start_copy(8'h33, 8'h44, 8'd0);
    check_outs("zero_done", 1, 12'h400);
    step();
    check_outs("zero_idle", 2, 12'h000);
  endtask

  task automatic test_wrap();
    poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33);
    start_copy(8'hFE, 8'h40, 8'd3);
    check_outs("wrap_rd0", 1, {4'b1010, 8'hFE});
    step(); step();
    check_outs("wrap_rd1", 3, {4'b1010, 8'hFF});
    step(); step();
    check_outs("wrap_rd2", 5, {4'b1010, 8'h00});
    step(); step();
    check_outs("wrap_done", 7, 12'h400);
    step();
    check_mem("wrap_mem", 8'h40, 8'h11);
    check_mem("wrap_mem", 8'h41, 8'h22);
    check_mem("wrap_mem", 8'h42, 8'h33);
  endtask

  task automatic test_overlap();
    poke(8'h20, 8'h5A); poke(8'h21, 8'h01); poke(8'h22, 8'h02); poke(8'h23, 8'h03);
    start_copy(8'h20, 8'h21, 8'd3);
    for (int c = 1; c <= 7; c++) step();
    check_mem("overlap_mem", 8'h21, 8'h5A);
    check_mem("overlap_mem", 8'h22, 8'h5A);
    check_mem("overlap_mem", 8'h23, 8'h5A);
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 8; i++) begin
      poke(8'h50 + 8'(i), 8'h60 + 8'(i));
      poke(8'hA0 + 8'(i), 8'hEE);
    end
    start_copy(8'h50, 8'hA0, 8'd8);
    step(); step(); step();
    check_outs("abort_wr2", 4, {4'b1001, 8'hA1});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outs("abort_outs", 5, 12'h000);
    checks++;
    if (bus.Remaining !== 8'h00) begin
      failures++;
      $display("FAIL abort_rem actual=%02h required=00", bus.Remaining);
    end
    for (int c = 6; c <= 10; c++) begin
      check_outs("abort_quiet", c, 12'h000);
      step();
    end
    check_mem("abort_mem", 8'hA0, 8'h60);
    check_mem("abort_mem", 8'hA1, 8'h61);
    check_mem("abort_mem", 8'hA2, 8'hEE);
  endtask

  task automatic test_start_ignored();
    logic [7:0] exp_rem;
    start_copy(8'h10, 8'hC0, 8'd4);
    for (int c = 1; c <= 9; c++) begin
      exp_rem = (c == 9) ? 8'd0 : 8'(4 - (c - 1) / 2);
      checks++;
      if (bus.Remaining !== exp_rem) begin
        failures++;
        $display("FAIL busy_start_rem cycle=%0d actual=%0d required=%0d", c, bus.Remaining, exp_rem);
      end
      if (c == 3) check_outs("busy_start_addr", c, {4'b1010, 8'h11});
      bus.Start = (c == 2 || c == 9);
      bus.SrcAddr = 8'h99; bus.DstAddr = 8'h77; bus.Length = 8'd9;
      step();
      bus.Start = 1'b0;
    end
    check_outs("done_start_idle", 10, 12'h000);
    step();
    check_outs("done_start_idle2", 11, 12'h000);
    check_mem("busy_start_mem", 8'hC3, 8'hD4);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    bus.Start = 1'b0; bus.SrcAddr = '0; bus.DstAddr = '0; bus.Length = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_basic_copy();
    test_zero_length();
    test_wrap();
    test_overlap();
    test_reset_abort();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ReadMem and WriteMem must never overlap
  always @(negedge clk) begin
    if (bus.ReadMem && bus.WriteMem) begin
      failures++;
      $display("FAIL strobe_overlap actual=both required=exclusive");
    end
  end

endmodule
